// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet MII transmit framer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG,
        ERR
    } tx_state_e;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    localparam int unsigned DEF_PREAMBLE_NIBBLES = 15;
    localparam int unsigned DEF_IFG_NIBBLES      = 24;
    localparam int unsigned DEF_MIN_FRAME_BYTES  = 60;

    localparam logic [10:0] BYTE_CNT_MAX = '1;

endpackage

// File: rtl/eth_crc32_nibble.sv
// Combinational one-nibble step of the reflected Ethernet CRC-32.
module eth_crc32_nibble
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [3:0]  nibble_i,
    output logic [31:0] crc_o
);

    // Fold the nibble in LSB-first, one polynomial step per bit.
    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {28'h0, nibble_i};
        for (int unsigned i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_tx_mii_framer.sv
// Ethernet MAC transmit framer driving the MII TX pins on MTxClk.
// Sequence: preamble, SFD, data nibbles, optional pad, FCS, inter-frame gap.
// Build option ETH_TX_PAD_EN: pad frames shorter than MIN_FRAME_BYTES with
// zero bytes before the FCS; without it the FCS follows the last byte directly.
module eth_tx_mii_framer
    import eth_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_NIBBLES = DEF_PREAMBLE_NIBBLES,
    parameter int unsigned IFG_NIBBLES      = DEF_IFG_NIBBLES,
    parameter int unsigned MIN_FRAME_BYTES  = DEF_MIN_FRAME_BYTES
) (
    input  logic       MTxClk,
    input  logic       TxReset,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_eof_i,
    output logic       tx_ready_o,
    input  logic       MCrS,
    output logic [3:0] MTxD,
    output logic       MTxEn,
    output logic       MTxErr,
    output logic       tx_done_o,
    output logic       tx_underrun_o
);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_NIBBLES - 1);
    localparam logic [10:0] MIN_B    = 11'(MIN_FRAME_BYTES);

    tx_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;       // 0: low nibble cycle, 1: high nibble cycle
    logic [7:0]  data_q, data_d;
    logic        eof_q, eof_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        done_q, done_d;

    logic [3:0]  data_nib;
    logic [3:0]  crc_nib;
    logic [31:0] crc_nxt;
    logic [31:0] fcs;
    logic [10:0] byte_cnt_inc;
    logic        short_frame;
    logic        start;

    assign data_nib     = phase_q ? data_q[7:4] : data_q[3:0];
    assign crc_nib      = (state_q == DATA) ? data_nib : 4'h0;
    assign fcs          = ~crc_q;
    assign byte_cnt_inc = (byte_cnt_q == BYTE_CNT_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign short_frame  = byte_cnt_inc < MIN_B;
    assign tx_done_o    = done_q;

    eth_crc32_nibble u_crc (
        .crc_i    (crc_q),
        .nibble_i (crc_nib),
        .crc_o    (crc_nxt)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge MTxClk) begin
        if (TxReset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            data_q     <= '0;
            eof_q      <= 1'b0;
            byte_cnt_q <= '0;
            crc_q      <= CRC_INIT;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            data_q     <= data_d;
            eof_q      <= eof_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            done_q     <= done_d;
        end
    end

    // Next-state, handshake and MII pin decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        data_d        = data_q;
        eof_d         = eof_q;
        byte_cnt_d    = byte_cnt_q;
        crc_d         = crc_q;
        done_d        = 1'b0;
        start         = 1'b0;
        tx_ready_o    = 1'b0;
        MTxD          = '0;
        MTxEn         = 1'b0;
        MTxErr        = 1'b0;
        tx_underrun_o = 1'b0;

        case (state_q)
            IDLE: begin
                start = tx_valid_i && !MCrS;
            end
            PREAMBLE: begin
                MTxEn = 1'b1;
                MTxD  = PREAMBLE_NIB;
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SFD: begin
                MTxEn      = 1'b1;
                MTxD       = SFD_NIB;
                tx_ready_o = 1'b1;
                if (tx_valid_i) begin
                    data_d  = tx_data_i;
                    eof_d   = tx_eof_i;
                    phase_d = 1'b0;
                    state_d = DATA;
                end else begin
                    state_d = ERR;
                end
            end
            DATA: begin
                MTxEn = 1'b1;
                MTxD  = data_nib;
                crc_d = crc_nxt;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    byte_cnt_d = byte_cnt_inc;
                    if (eof_q) begin
                        state_d = (PAD_EN && short_frame) ? PAD : FCS;
                        cnt_d   = '0;
                    end else begin
                        tx_ready_o = 1'b1;
                        if (tx_valid_i) begin
                            data_d = tx_data_i;
                            eof_d  = tx_eof_i;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                MTxEn = 1'b1;
                crc_d = crc_nxt;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    byte_cnt_d = byte_cnt_inc;
                    if (!short_frame) begin
                        state_d = FCS;
                        cnt_d   = '0;
                    end
                end
            end
`endif
            FCS: begin
                MTxEn = 1'b1;
                MTxD  = fcs[{cnt_q[2:0], 2'b00} +: 4];
                if (cnt_q[2:0] == 3'd7) begin
                    state_d = IFG;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            IFG: begin
                // The last gap cycle applies the idle start rule itself so a
                // pending frame follows after exactly IFG_NIBBLES low cycles.
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    start   = tx_valid_i && !MCrS;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ERR: begin
                MTxEn         = 1'b1;
                MTxErr        = 1'b1;
                tx_underrun_o = 1'b1;
                state_d       = IFG;
                cnt_d         = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            state_d    = PREAMBLE;
            cnt_d      = '0;
            phase_d    = 1'b0;
            eof_d      = 1'b0;
            byte_cnt_d = '0;
            crc_d      = CRC_INIT;
        end
    end

endmodule

// File: tb/tb_eth_tx_mii_framer.sv
// Directed scoreboard bench for eth_tx_mii_framer (either ETH_TX_PAD_EN build).
`timescale 1ns/1ps
module tb_eth_tx_mii_framer;

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int PRE  = 15;
    localparam int MINF = 60;

    logic       MTxClk = 1'b0;
    logic       TxReset = 1'b1;
    logic       tx_valid_i = 1'b0;
    logic [7:0] tx_data_i = '0;
    logic       tx_eof_i = 1'b0;
    logic       MCrS = 1'b0;
    logic       tx_ready_o, MTxEn, MTxErr, tx_done_o, tx_underrun_o;
    logic [3:0] MTxD;

    always #5 MTxClk = ~MTxClk;

    eth_tx_mii_framer dut (
        .MTxClk        (MTxClk),
        .TxReset       (TxReset),
        .tx_valid_i    (tx_valid_i),
        .tx_data_i     (tx_data_i),
        .tx_eof_i      (tx_eof_i),
        .tx_ready_o    (tx_ready_o),
        .MCrS          (MCrS),
        .MTxD          (MTxD),
        .MTxEn         (MTxEn),
        .MTxErr        (MTxErr),
        .tx_done_o     (tx_done_o),
        .tx_underrun_o (tx_underrun_o)
    );

    int tests = 0;
    int fails = 0;
    logic [4:0] exp_q[$];      // {MTxErr, MTxD} per MTxEn-high cycle
    logic [7:0] fr[$];
    logic [4:0] e;
    bit mon_en = 1'b0;
    int en_run = 0, low_run = 0, last_en_run = 0, last_gap = 0;
    int done_cnt = 0, under_cnt = 0;
    int d0, u0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic int en_cycles(input int len);
        int l;
        l = (PAD_EN && len < MINF) ? MINF : len;
        return PRE + 1 + 2 * l + 8;
    endfunction

    // Expected nibble stream for fr; trunc >= 0 models an underrun after trunc bytes.
    task automatic push_frame(input int trunc);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        int n;
        crc = 32'hFFFFFFFF;
        n = fr.size();
        for (int i = 0; i < PRE; i++) exp_q.push_back(5'h05);
        exp_q.push_back(5'h0D);
        if (trunc >= 0) begin
            for (int i = 0; i < trunc; i++) begin
                b = fr[i];
                exp_q.push_back({1'b0, b[3:0]});
                exp_q.push_back({1'b0, b[7:4]});
            end
            exp_q.push_back(5'h10);
            return;
        end
        for (int i = 0; i < n || (PAD_EN && i < MINF); i++) begin
            b = (i < n) ? fr[i] : 8'h00;
            exp_q.push_back({1'b0, b[3:0]});
            exp_q.push_back({1'b0, b[7:4]});
            crc = crc_byte(crc, b);
        end
        fcs = ~crc;
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, fcs[k*4 +: 4]});
    endtask

    task automatic send(input int drop_after, input bit hold);
        int n;
        bit accepted;
        n = (drop_after >= 0) ? drop_after : fr.size();
        for (int i = 0; i < n; i++) begin
            tx_valid_i = 1'b1;
            tx_data_i  = fr[i];
            tx_eof_i   = (i == fr.size() - 1);
            accepted   = 1'b0;
            for (int g = 0; g < 300 && !accepted; g++) begin
                @(negedge MTxClk);
                if (tx_ready_o === 1'b1) begin
                    accepted = 1'b1;
                    @(posedge MTxClk);
                    #1;
                end
            end
            if (!accepted) begin
                check("accept_timeout", 32'(accepted), 1);
                tx_valid_i = 1'b0;
                return;
            end
        end
        if (!hold) begin
            tx_valid_i = 1'b0;
            tx_eof_i   = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (g < 3000 && (exp_q.size() != 0 || MTxEn !== 1'b0)) begin
            @(negedge MTxClk);
            g++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) @(negedge MTxClk);
    endtask

    // Monitor: pops the scoreboard on every MTxEn-high cycle, checks idle lines otherwise.
    always @(negedge MTxClk) begin
        if (mon_en) begin
            if (MTxEn === 1'b1) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
                en_run++;
                if (exp_q.size() == 0) begin
                    check("tx_when_idle", 32'(MTxEn), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("nibble", {27'h0, MTxErr, MTxD}, {27'h0, e});
                end
            end else begin
                if (en_run > 0) last_en_run = en_run;
                en_run = 0;
                low_run++;
                check("idle_lines", {27'h0, MTxErr, MTxD}, 0);
            end
            if (tx_done_o === 1'b1) done_cnt++;
            if (tx_underrun_o === 1'b1) under_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge MTxClk);
        #1;
        mon_en = 1'b1;
        @(negedge MTxClk);
        check("rst_en", 32'(MTxEn), 0);
        check("rst_err", 32'(MTxErr), 0);
        check("rst_txd", 32'(MTxD), 0);
        check("rst_ready", 32'(tx_ready_o), 0);
        check("rst_done", 32'(tx_done_o), 0);
        check("rst_underrun", 32'(tx_underrun_o), 0);
        @(posedge MTxClk);
        #1;
        TxReset = 1'b0;
        repeat (3) @(posedge MTxClk);
        #1;

        // 1: "123456789"
        fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        d0 = done_cnt; u0 = under_cnt;
        push_frame(-1);
        send(-1, 1'b0);
        drain("t1");
        check("t1_en_cycles", last_en_run, PAD_EN ? 144 : 42);
        check("t1_done", done_cnt, d0 + 1);
        check("t1_underrun", under_cnt, u0);
        repeat (30) @(negedge MTxClk);

        // 2: single byte 0xA5
        fr = {8'hA5};
        d0 = done_cnt;
        push_frame(-1);
        @(posedge MTxClk); #1;
        send(-1, 1'b0);
        drain("t2");
        check("t2_en_cycles", last_en_run, PAD_EN ? 144 : 26);
        check("t2_done", done_cnt, d0 + 1);
        repeat (30) @(negedge MTxClk);

        // 3: back-to-back frames, valid held high
        fr = {8'h10, 8'h22, 8'h34, 8'h48, 8'h5F};
        d0 = done_cnt;
        push_frame(-1);
        push_frame(-1);
        @(posedge MTxClk); #1;
        send(-1, 1'b1);
        send(-1, 1'b0);
        drain("t3");
        check("t3_ifg_gap", last_gap, 24);
        check("t3_en_cycles", last_en_run, en_cycles(5));
        check("t3_done", done_cnt, d0 + 2);
        repeat (30) @(negedge MTxClk);

        // 4: carrier sense defers frame start
        fr = {8'h55, 8'hC3};
        push_frame(-1);
        @(posedge MTxClk); #1;
        MCrS       = 1'b1;
        tx_valid_i = 1'b1;
        tx_data_i  = fr[0];
        tx_eof_i   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge MTxClk);
            check("t4_defer", 32'(MTxEn), 0);
        end
        @(posedge MTxClk); #1;
        MCrS = 1'b0;
        @(negedge MTxClk);
        check("t4_fall_cycle", 32'(MTxEn), 0);
        @(negedge MTxClk);
        check("t4_start", 32'(MTxEn), 1);
        send(-1, 1'b0);
        drain("t4");
        check("t4_en_cycles", last_en_run, en_cycles(2));
        repeat (30) @(negedge MTxClk);

        // 5: underrun after 3 of 20 bytes
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'(i * 7 + 1));
        d0 = done_cnt; u0 = under_cnt;
        push_frame(3);
        @(posedge MTxClk); #1;
        send(3, 1'b0);
        drain("t5");
        check("t5_en_cycles", last_en_run, PRE + 1 + 6 + 1);
        check("t5_underrun", under_cnt, u0 + 1);
        check("t5_done", done_cnt, d0);
        repeat (30) @(negedge MTxClk);
        check("t5_ifg_quiet", 32'(MTxEn), 0);

        // 6: TxReset mid-DATA, then a clean frame
        d0 = done_cnt;
        push_frame(-1);
        @(posedge MTxClk); #1;
        send(4, 1'b0);
        TxReset = 1'b1;
        @(posedge MTxClk); #1;
        exp_q.delete();
        check("t6_en", 32'(MTxEn), 0);
        check("t6_err", 32'(MTxErr), 0);
        check("t6_ready", 32'(tx_ready_o), 0);
        check("t6_txd", 32'(MTxD), 0);
        @(posedge MTxClk); #1;
        TxReset = 1'b0;
        repeat (30) @(negedge MTxClk);
        check("t6_no_done", done_cnt, d0);
        check("t6_quiet", 32'(MTxEn), 0);
        fr = {8'h7E};
        push_frame(-1);
        @(posedge MTxClk); #1;
        send(-1, 1'b0);
        drain("t6");
        check("t6_en_cycles", last_en_run, en_cycles(1));
        check("t6_done", done_cnt, d0 + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
